fcmp_pipe: RTL and testbench
============================

Name: fcmp_pipe

Overview:
- Parametrised, pipelined floating-point compare unit; successor to the single-cycle less-than comparator.
- Supports three opcodes, FEQ, FLT and FLE, with IEEE-754 NaN and signed-zero semantics, a RISC-V-style invalid flag and a sticky flag accumulator.
- Sits in the FPU issue path behind the operand mux.
- Uses a valid/ready handshake so the writeback arbiter can stall it.

Parameters:
- EXP_W, 8, exponent width in bits.
- MAN_W, 23, mantissa width in bits. Operand width W = 1 + EXP_W + MAN_W.
- LAT, 2, pipeline depth in cycles, legal range 1..4. Values outside this range are a generate-time error.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- in_valid  in  1  operands and op are valid.
- in_ready  out  1  unit accepts an operation this cycle.
- x1  in  W  operand a.
- x2  in  W  operand b.
- op  in  2  00=FEQ, 01=FLT, 10=FLE, 11=reserved.
- out_valid  out  1  result is valid.
- out_ready  in  1  consumer accepts the result.
- y  out  1  compare result.
- nv  out  1  invalid-operation flag for this result.
- flag_nv  out  1  sticky OR of nv over all retired results.
- flag_clr  in  1  synchronous clear of flag_nv.

Behaviour:
- Reset (async, any cycle, including mid-operation):
  - All stage valid bits, y, nv, out_valid and flag_nv are forced to 0.
  - In-flight operations are discarded; no result is emitted for them after reset deasserts.
  - in_ready is 1 out of reset.
- Classification:
  - NaN: exponent all ones and mantissa != 0.
  - sNaN: NaN with mantissa MSB = 0. qNaN: NaN with mantissa MSB = 1.
  - Zero: exponent = 0 and mantissa = 0, either sign.
- Magnitude compare uses the W-1 low bits, unsigned. Denormals compare by bit pattern; no flushing.
- Ordering when neither operand is NaN:
  - Both zero: equal.
  - Otherwise signs differ: the negative operand is less.
  - Both positive: less iff |a| < |b|.
  - Both negative: less iff |a| > |b|.
- Results:
  - FEQ: y = equal.
  - FLT: y = less.
  - FLE: y = less OR equal.
  - Any NaN operand: y = 0.
  - Reserved op: y = 0, nv = 0.
- nv:
  - FEQ: nv = 1 iff either operand is sNaN.
  - FLT/FLE: nv = 1 iff either operand is any NaN.
- Pipeline:
  - The result is computed combinationally from the inputs, then carried through LAT register stages. Each stage holds {valid, y, nv}.
  - stall = out_valid AND NOT out_ready.
  - When stall = 0, all stages shift on the clock edge: stage0 <= {in_valid, result}.
  - When stall = 1, all stages hold.
  - in_ready = NOT stall. This is purely combinational from out_valid and out_ready.
  - Bubbles are not collapsed.
  - Latency: a transfer accepted at edge t appears on out_valid after edge t+LAT-1, i.e. it is visible in the cycle following the LAT-th rising edge counted from acceptance.
  - Throughput is one operation per cycle while out_ready = 1.
  - Outputs y, nv and out_valid come directly from the last stage register.
  - y and nv are held stable while out_valid = 1 and out_ready = 0.
- Sticky flag:
  - On each retiring handshake (out_valid AND out_ready), flag_nv <= flag_nv OR nv.
  - flag_clr has priority over a set in the same cycle: flag_nv <= 0.
  - A set occurring in the cycle after the clear takes effect normally.
- in_valid = 0 while stall = 0 inserts a bubble. Operands are don't-care when in_valid = 0.

Test Plan:
- LAT=2, out_ready=1, FLT x1=0x3F800000 (1.0), x2=0x40000000 (2.0) -> out_valid=1 exactly 2 cycles after acceptance, y=1, nv=0. Swapping the operands gives y=0.
- FEQ x1=0x00000000, x2=0x80000000 -> y=1. FLT on the same operands -> y=0. FLE -> y=1.
- Negatives: FLT x1=0xBF800000 (-1.0), x2=0xC0000000 (-2.0) -> y=0. FLT x1=0xC0000000, x2=0xBF800000 -> y=1.
- NaN flags:
  - FEQ with x2=0x7FC00000 (qNaN) -> y=0, nv=0.
  - FEQ with x2=0x7F800001 (sNaN) -> y=0, nv=1.
  - FLE with a qNaN operand -> y=0, nv=1.
  - flag_nv then reads 1 until flag_clr is pulsed, then reads 0.
- Backpressure: stream 6 back-to-back ops with out_ready=0 for cycles 3..5 ->
  - in_ready=0 exactly while out_valid AND NOT out_ready.
  - No op is lost or duplicated; results retire in issue order.
  - y is held stable during the stall.
- Reset mid-flight: assert rst asynchronously (between clock edges) while 2 ops are in the pipe -> out_valid and flag_nv drop to 0 immediately. After release, no stale result appears in the next LAT cycles.

Source files
------------

// File: rtl/fcmp_pipe.sv
// Pipelined IEEE-754 compare (FEQ/FLT/FLE) with invalid flag, sticky flag accumulator
// and a valid/ready output handshake; the whole pipe freezes while the result is stalled.
module fcmp_pipe #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23,
    parameter int LAT   = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [EXP_W+MAN_W:0]   x1,
    input  logic [EXP_W+MAN_W:0]   x2,
    input  logic [1:0]             op,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   y,
    output logic                   nv,
    output logic                   flag_nv,
    input  logic                   flag_clr
);

    generate
        if (LAT < 1 || LAT > 4) begin : g_bad_lat
            $error("fcmp_pipe: LAT must be in 1..4");
        end
    endgenerate

    typedef enum logic [1:0] {
        OP_FEQ = 2'b00,
        OP_FLT = 2'b01,
        OP_FLE = 2'b10,
        OP_RSV = 2'b11
    } op_e;

    logic                   sign_a, sign_b;
    logic [EXP_W-1:0]       exp_a, exp_b;
    logic [MAN_W-1:0]       man_a, man_b;
    logic [EXP_W+MAN_W-1:0] mag_a, mag_b;
    logic                   nan_a, nan_b, snan_a, snan_b, any_nan, any_snan;
    logic                   both_zero, eq, lt;
    logic                   res_y, res_nv;

    assign sign_a = x1[EXP_W+MAN_W];
    assign sign_b = x2[EXP_W+MAN_W];
    assign exp_a  = x1[MAN_W +: EXP_W];
    assign exp_b  = x2[MAN_W +: EXP_W];
    assign man_a  = x1[MAN_W-1:0];
    assign man_b  = x2[MAN_W-1:0];
    assign mag_a  = x1[EXP_W+MAN_W-1:0];
    assign mag_b  = x2[EXP_W+MAN_W-1:0];

    assign nan_a    = (&exp_a) & (|man_a);
    assign nan_b    = (&exp_b) & (|man_b);
    assign snan_a   = nan_a & ~man_a[MAN_W-1];
    assign snan_b   = nan_b & ~man_b[MAN_W-1];
    assign any_nan  = nan_a | nan_b;
    assign any_snan = snan_a | snan_b;

    // +0 and -0 are the only distinct encodings that compare equal
    assign both_zero = ~(|mag_a) & ~(|mag_b);
    assign eq        = both_zero | (x1 == x2);

    always_comb begin
        lt = 1'b0;
        if (both_zero) begin
            lt = 1'b0;
        end else if (sign_a != sign_b) begin
            lt = sign_a;
        end else if (sign_a) begin
            lt = (mag_b < mag_a);
        end else begin
            lt = (mag_a < mag_b);
        end
    end

    always_comb begin
        res_y  = 1'b0;
        res_nv = 1'b0;
        case (op_e'(op))
            OP_FEQ: begin
                res_y  = ~any_nan & eq;
                res_nv = any_snan;
            end
            OP_FLT: begin
                res_y  = ~any_nan & lt;
                res_nv = any_nan;
            end
            OP_FLE: begin
                res_y  = ~any_nan & (lt | eq);
                res_nv = any_nan;
            end
            default: begin
                res_y  = 1'b0;
                res_nv = 1'b0;
            end
        endcase
    end

    logic [LAT-1:0] st_v, st_y, st_nv;
    logic           stall;

    assign out_valid = st_v[LAT-1];
    assign y         = st_y[LAT-1];
    assign nv        = st_nv[LAT-1];
    assign stall     = out_valid & ~out_ready;
    assign in_ready  = ~stall;

    // Bubbles carry zeroed payload so an idle stage never holds stale flags
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st_v  <= '0;
            st_y  <= '0;
            st_nv <= '0;
        end else if (!stall) begin
            st_v[0]  <= in_valid;
            st_y[0]  <= in_valid & res_y;
            st_nv[0] <= in_valid & res_nv;
            for (int i = 1; i < LAT; i++) begin
                st_v[i]  <= st_v[i-1];
                st_y[i]  <= st_y[i-1];
                st_nv[i] <= st_nv[i-1];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flag_nv <= 1'b0;
        end else if (flag_clr) begin
            flag_nv <= 1'b0;
        end else if (out_valid && out_ready) begin
            flag_nv <= flag_nv | nv;
        end
    end

endmodule

// File: tb/tb_fcmp_pipe.sv
// Directed bench for fcmp_pipe: expected {y,nv} are queued on acceptance and
// checked in order as results retire; also checks latency, stall hold, sticky flag, reset.
module tb_fcmp_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] x1, x2;
    logic [1:0]  op;
    logic        out_valid;
    logic        out_ready;
    logic        y, nv;
    logic        flag_nv;
    logic        flag_clr;

    typedef struct {
        logic  y;
        logic  nv;
        string tag;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;

    logic held_valid = 1'b0;
    logic held_y, held_nv;

    localparam logic [1:0] FEQ = 2'b00, FLT = 2'b01, FLE = 2'b10, RSV = 2'b11;

    fcmp_pipe #(.EXP_W(8), .MAN_W(23), .LAT(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x1        (x1),
        .x2        (x2),
        .op        (op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .y         (y),
        .nv        (nv),
        .flag_nv   (flag_nv),
        .flag_clr  (flag_clr)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        tests++;
        assert (observed === expected) else begin
            fails++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // One clock cycle of stimulus, entered just after a rising edge
    task automatic applyStimulus(input logic v, input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                                 input logic ey, input logic env, input logic ordy, input string tag,
                                 output logic acc);
        exp_t e;
        in_valid  = v;
        op        = o;
        x1        = a;
        x2        = b;
        out_ready = ordy;
        @(negedge clk);
        acc = v && in_ready;
        if (acc) begin
            e.y   = ey;
            e.nv  = env;
            e.tag = tag;
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic issueOp(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                           input logic ey, input logic env, input string tag);
        logic acc;
        acc = 1'b0;
        for (int n = 0; n < 20 && !acc; n++) begin
            applyStimulus(1'b1, o, a, b, ey, env, 1'b1, tag, acc);
        end
        if (!acc) checkOutput({tag, "_accept_timeout"}, acc, 1);
    endtask

    task automatic idle(input int n);
        logic acc;
        for (int k = 0; k < n; k++) begin
            applyStimulus(1'b0, FEQ, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, "idle", acc);
        end
    endtask

    // Output monitor: handshake-ordered scoreboard, in_ready law, hold-during-stall
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            held_valid = 1'b0;
        end else begin
            checkOutput("in_ready", in_ready, !(out_valid && !out_ready));
            if (held_valid) begin
                checkOutput("hold_y", y, held_y);
                checkOutput("hold_nv", nv, held_nv);
                checkOutput("hold_valid", out_valid, 1);
            end
            if (out_valid && out_ready) begin
                checkOutput("no_spurious_result", sb.size() != 0, 1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    checkOutput({e.tag, "_y"}, y, e.y);
                    checkOutput({e.tag, "_nv"}, nv, e.nv);
                end
            end
            held_valid = out_valid && !out_ready;
            held_y     = y;
            held_nv    = nv;
        end
    end

    logic [1:0]  bp_op[6];
    logic [31:0] bp_a[6], bp_b[6];
    logic        bp_y[6];

    initial begin
        logic acc;
        int   idx;

        rst = 1'b1; in_valid = 1'b0; x1 = '0; x2 = '0; op = FEQ;
        out_ready = 1'b1; flag_clr = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_out_valid", out_valid, 0);
        checkOutput("rst_in_ready", in_ready, 1);
        checkOutput("rst_flag_nv", flag_nv, 0);
        checkOutput("rst_y", y, 0);
        checkOutput("rst_nv", nv, 0);
        rst = 1'b0;

        // Latency: accepted at edge t, visible after edge t+1
        issueOp(FLT, 32'h3F800000, 32'h40000000, 1'b1, 1'b0, "flt_1_2");
        @(negedge clk);
        checkOutput("lat_early", out_valid, 0);
        @(negedge clk);
        checkOutput("lat_on_time", out_valid, 1);
        @(posedge clk);
        #1;
        issueOp(FLT, 32'h40000000, 32'h3F800000, 1'b0, 1'b0, "flt_2_1");

        // Signed zero
        issueOp(FEQ, 32'h00000000, 32'h80000000, 1'b1, 1'b0, "feq_zeros");
        issueOp(FLT, 32'h00000000, 32'h80000000, 1'b0, 1'b0, "flt_zeros");
        issueOp(FLE, 32'h00000000, 32'h80000000, 1'b1, 1'b0, "fle_zeros");

        // Negatives
        issueOp(FLT, 32'hBF800000, 32'hC0000000, 1'b0, 1'b0, "flt_m1_m2");
        issueOp(FLT, 32'hC0000000, 32'hBF800000, 1'b1, 1'b0, "flt_m2_m1");
        issueOp(FLE, 32'h80000001, 32'h00000001, 1'b1, 1'b0, "fle_denorm_sign");
        idle(3);
        checkOutput("flag_clean", flag_nv, 0);

        // NaN handling
        issueOp(FEQ, 32'h3F800000, 32'h7FC00000, 1'b0, 1'b0, "feq_qnan");
        issueOp(RSV, 32'h7F800001, 32'h7F800001, 1'b0, 1'b0, "rsv_snan");
        idle(3);
        checkOutput("flag_after_qnan_feq", flag_nv, 0);
        issueOp(FEQ, 32'h3F800000, 32'h7F800001, 1'b0, 1'b1, "feq_snan");
        issueOp(FLE, 32'h7FC00000, 32'h3F800000, 1'b0, 1'b1, "fle_qnan");
        issueOp(FEQ, 32'h7F800000, 32'h7F800000, 1'b1, 1'b0, "feq_inf");
        idle(3);
        checkOutput("flag_set", flag_nv, 1);
        idle(2);
        checkOutput("flag_sticky", flag_nv, 1);
        flag_clr = 1'b1;
        idle(1);
        flag_clr = 1'b0;
        checkOutput("flag_cleared", flag_nv, 0);

        // Clear beats a same-cycle set; a set the next cycle still lands
        issueOp(FLT, 32'h7FC00000, 32'h0, 1'b0, 1'b1, "flt_qnan_a");
        issueOp(FLT, 32'h0, 32'h7FC00000, 1'b0, 1'b1, "flt_qnan_b");
        flag_clr = 1'b1;
        idle(1);
        flag_clr = 1'b0;
        checkOutput("flag_clr_priority", flag_nv, 0);
        idle(1);
        checkOutput("flag_set_after_clr", flag_nv, 1);
        idle(2);

        // Backpressure: six back-to-back ops, consumer stalls in cycles 3..5
        bp_op = '{FLT, FLE, FEQ, FLT, FLE, FLT};
        bp_a  = '{32'h3F800000, 32'h40000000, 32'h40000000, 32'h80000000, 32'h7F7FFFFF, 32'h00000002};
        bp_b  = '{32'h40000000, 32'h3F800000, 32'h40000000, 32'h00000000, 32'h7F800000, 32'h00000001};
        bp_y  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        idx = 0;
        for (int c = 0; c < 40 && (idx < 6 || sb.size() != 0); c++) begin
            if (idx < 6) begin
                applyStimulus(1'b1, bp_op[idx], bp_a[idx], bp_b[idx], bp_y[idx], 1'b0,
                              !(c >= 3 && c <= 5), $sformatf("bp%0d", idx), acc);
                if (acc) idx++;
            end else begin
                applyStimulus(1'b0, FEQ, 32'h0, 32'h0, 1'b0, 1'b0, !(c >= 3 && c <= 5), "idle", acc);
            end
        end
        checkOutput("bp_all_issued", idx, 6);
        checkOutput("bp_all_retired", sb.size(), 0);

        // Reset while two ops are in flight
        issueOp(FEQ, 32'h7F800001, 32'h0, 1'b0, 1'b1, "pre_rst_snan");
        idle(3);
        checkOutput("pre_rst_flag", flag_nv, 1);
        issueOp(FLT, 32'h3F800000, 32'h40000000, 1'b1, 1'b0, "inflight0");
        issueOp(FLT, 32'h3F800000, 32'h40000000, 1'b1, 1'b0, "inflight1");
        #2;
        checkOutput("pre_rst_out_valid", out_valid, 1);
        rst = 1'b1;
        sb.delete();
        #1;
        checkOutput("async_rst_out_valid", out_valid, 0);
        checkOutput("async_rst_flag", flag_nv, 0);
        checkOutput("async_rst_in_ready", in_ready, 1);
        @(posedge clk);
        #3;
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            idle(1);
            checkOutput("post_rst_no_stale", out_valid, 0);
        end
        issueOp(FLE, 32'hC0000000, 32'hC0000000, 1'b1, 1'b0, "post_rst_fle");
        idle(3);
        checkOutput("post_rst_drained", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
